mem_bus_arbiter: RTL and testbench

- Shares one single-port, ack-handshaked data/instruction RAM between the fetch (inst) port and the MEM-stage (data) port of the 5-stage core.
- Each transaction is serialised onto the RAM bus through a small FSM.
- Raises per-port stall requests toward the stall controller and holds each port's read result until the pipeline advances.

---
 rtl/mem_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one ack-handshaked RAM bus between the fetch and MEM-stage ports.
// Define ARB_RR_EN for round-robin grant on collisions (default: DATA over INST).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    input  logic                inst_ce_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic [DATA_W-1:0]   inst_o,
    output logic                stallreq_inst_o,
    input  logic                data_ce_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_sel_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                stallreq_data_o,
    output logic                ram_ce_o,
    output logic                ram_we_o,
    output logic [DATA_W/8-1:0] ram_sel_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_data_o,
    input  logic [DATA_W-1:0]   ram_data_i,
    input  logic                ram_ack_i
);
    localparam int unsigned SelW = DATA_W / 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StData = 2'd1;
    localparam logic [1:0] StInst = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic [SelW-1:0]   ram_sel_q, ram_sel_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic              inst_kill_q, inst_kill_d;

    logic data_pend, inst_pend, data_ack, inst_ack;
    logic data_take, inst_take, grant_data, grant_inst;

    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    assign data_pend = data_ce_i & ~data_done_q;
    assign inst_pend = inst_ce_i & ~inst_done_q & ~flush_i;
    assign data_ack  = (state_q == StData) & ram_ack_i;
    assign inst_ack  = (state_q == StInst) & ram_ack_i;
    assign data_take = data_ack & data_ce_i;
    // A fetch flushed at any point of its transaction never delivers its word.
    assign inst_take = inst_ack & inst_ce_i & ~flush_i & ~inst_kill_q;

`ifdef ARB_RR_EN
    logic last_data_q, last_data_d;

    assign grant_data = (state_q == StIdle) & data_pend & (~inst_pend | ~last_data_q);

    always_comb begin
        last_data_d = last_data_q;
        if (grant_data) begin
            last_data_d = 1'b1;
        end else if (grant_inst) begin
            last_data_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign grant_data = (state_q == StIdle) & data_pend;
`endif
    assign grant_inst = (state_q == StIdle) & inst_pend & ~grant_data;

    always_comb begin
        state_d     = state_q;
        ram_ce_d    = ram_ce_q;
        ram_we_d    = ram_we_q;
        ram_sel_d   = ram_sel_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            StIdle: begin
                if (grant_data) begin
                    state_d     = StData;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = data_we_i;
                    ram_sel_d   = data_sel_i;
                    ram_addr_d  = data_addr_i;
                    ram_wdata_d = data_wdata_i;
                end else if (grant_inst) begin
                    state_d    = StInst;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_sel_d  = '1;
                    ram_addr_d = inst_addr_i;
                end
            end
            StData, StInst: begin
                if (ram_ack_i) begin
                    state_d  = StIdle;
                    ram_ce_d = 1'b0;
                end
            end
            default: begin
                state_d  = StIdle;
                ram_ce_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        inst_kill_d = (state_q == StInst) & ~ram_ack_i & (inst_kill_q | flush_i);
        data_d      = (data_take & ~ram_we_q) ? ram_data_i : data_q;
        inst_d      = inst_take ? ram_data_i : inst_q;
        // Clearing wins so a word taken while the pipeline advances is not re-marked done.
        if (!stall_i[4] || !data_ce_i) begin
            data_done_d = 1'b0;
        end else begin
            data_done_d = data_done_q | data_take;
        end
        if (!stall_i[1] || !inst_ce_i || flush_i) begin
            inst_done_d = 1'b0;
        end else begin
            inst_done_d = inst_done_q | inst_take;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            inst_q      <= '0;
            data_q      <= '0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            inst_kill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            inst_q      <= inst_d;
            data_q      <= data_d;
            inst_done_q <= inst_done_d;
            data_done_q <= data_done_d;
            inst_kill_q <= inst_kill_d;
        end
    end

    assign stallreq_data_o = data_pend & ~data_ack;
    assign stallreq_inst_o = inst_pend & ~(inst_ack & ~inst_kill_q);
    assign data_rdata_o    = (data_take & ~ram_we_q) ? ram_data_i : data_q;
    assign inst_o          = inst_take ? ram_data_i : inst_q;

    assign ram_ce_o   = ram_ce_q;
    assign ram_we_o   = ram_we_q;
    assign ram_sel_o  = ram_sel_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_data_o = ram_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model and RAM responder.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic        inst_ce_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_o;
    logic        stallreq_inst_o;
    logic        data_ce_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_sel_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        stallreq_data_o;
    logic        ram_ce_o, ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o, ram_data_o;
    logic [31:0] ram_data_i = '0;
    logic        ram_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_o(inst_o),
        .stallreq_inst_o(stallreq_inst_o),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .stallreq_data_o(stallreq_data_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM responder: acks on the lat-th cycle that ram_ce_o is seen high.
    logic [31:0] mem [0:255];
    int lat = 1;
    int cnt = 0;
    always @(negedge clk) begin
        ram_ack_i  = 1'b0;
        ram_data_i = $urandom;
        if (!rst || !ram_ce_o) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt >= lat) begin
                cnt = 0;
                ram_ack_i = 1'b1;
                if (ram_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_sel_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] = ram_data_o[8*b +: 8];
                end else begin
                    ram_data_i = mem[ram_addr_o[9:2]];
                end
            end
        end
    end

    // Bus grants observed, one entry per transaction start.
    logic [31:0] grants[$];
    logic prev_ce = 1'b0;
    always @(negedge clk) begin
        #2;
        if (rst && ram_ce_o && !prev_ce) grants.push_back(ram_addr_o);
        prev_ce = rst && ram_ce_o;
    end

    // Reference model: one outstanding bus command, per-port done flags and held words.
    logic        m_on = 1'b0;
    logic        m_busy, m_port, m_we, m_ddone, m_idone, m_kill, m_last_data;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_dhold, m_ihold;
    logic        e_dpend, e_ipend, e_dtake, e_itake, e_gd;

    assign e_dpend = data_ce_i && !m_ddone;
    assign e_ipend = inst_ce_i && !m_idone && !flush_i;
    assign e_dtake = m_busy && m_port && ram_ack_i && data_ce_i;
    assign e_itake = m_busy && !m_port && ram_ack_i && inst_ce_i && !flush_i && !m_kill;
`ifdef ARB_RR_EN
    assign e_gd = e_dpend && (!e_ipend || !m_last_data);
`else
    assign e_gd = e_dpend;
`endif

    always @(posedge clk) begin
        if (!rst) begin
            m_on <= 1'b1; m_busy <= 1'b0; m_port <= 1'b0; m_we <= 1'b0;
            m_ddone <= 1'b0; m_idone <= 1'b0; m_kill <= 1'b0; m_last_data <= 1'b0;
            m_dhold <= '0; m_ihold <= '0; m_sel <= '0; m_addr <= '0; m_wdata <= '0;
        end else begin
            if (m_busy) begin
                if (ram_ack_i) begin
                    m_busy <= 1'b0;
                    m_kill <= 1'b0;
                    if (e_dtake && !m_we) m_dhold <= ram_data_i;
                    if (e_itake) m_ihold <= ram_data_i;
                end else if (!m_port && flush_i) begin
                    m_kill <= 1'b1;
                end
            end else if (e_dpend || e_ipend) begin
                m_busy      <= 1'b1;
                m_port      <= e_gd;
                m_last_data <= e_gd;
                m_we        <= e_gd ? data_we_i : 1'b0;
                m_sel       <= e_gd ? data_sel_i : 4'hF;
                m_addr      <= e_gd ? data_addr_i : inst_addr_i;
                m_wdata     <= data_wdata_i;
            end
            m_ddone <= (!stall_i[4] || !data_ce_i) ? 1'b0 : (m_ddone || e_dtake);
            m_idone <= (!stall_i[1] || !inst_ce_i || flush_i) ? 1'b0 : (m_idone || e_itake);
        end
    end

    always @(negedge clk) begin
        #3;
        if (m_on && rst) begin
            chk("stallreq_data", {31'b0, stallreq_data_o},
                {31'b0, e_dpend && !(m_busy && m_port && ram_ack_i)});
            chk("stallreq_inst", {31'b0, stallreq_inst_o},
                {31'b0, e_ipend && !(m_busy && !m_port && ram_ack_i && !m_kill)});
            chk("data_rdata", data_rdata_o, (e_dtake && !m_we) ? ram_data_i : m_dhold);
            chk("inst_out", inst_o, e_itake ? ram_data_i : m_ihold);
            chk("ram_ce", {31'b0, ram_ce_o}, {31'b0, m_busy});
            if (m_busy) begin
                chk("ram_addr", ram_addr_o, m_addr);
                chk("ram_we", {31'b0, ram_we_o}, {31'b0, m_we});
                chk("ram_sel", {28'b0, ram_sel_o}, {28'b0, m_sel});
                if (m_port) chk("ram_wdata", ram_data_o, m_wdata);
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_ce_i = 1'b0; data_ce_i = 1'b0; data_we_i = 1'b0;
        flush_i = 1'b0; stall_i = '0;
    endtask

    int hi, hid, bad;
    logic fin;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h3C010001;   // 0x100
        mem[8'h42] = 32'hDEADBEEF;   // 0x108
        mem[8'h80] = 32'h11112222;   // 0x200
        mem[8'h81] = 32'hFFFF0000;   // 0x204

        // Reset state
        rst = 1'b0;
        next_cycle(); next_cycle();
        rst = 1'b1;
        #4;
        chk("rst_ram_ce", {31'b0, ram_ce_o}, 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_data_rdata", data_rdata_o, 32'd0);
        chk("rst_stallreqs", {30'b0, stallreq_inst_o, stallreq_data_o}, 32'd0);
        next_cycle();

        // Lone fetch, ack on the third bus cycle
        lat = 3; inst_ce_i = 1'b1; inst_addr_i = 32'h100; stall_i = 6'b000010;
        hi = 0; bad = 0; fin = 1'b0;
        for (int c = 0; c < 10 && !fin; c++) begin
            #4;
            if (ram_ce_o && (ram_we_o !== 1'b0 || ram_sel_o !== 4'hF)) bad++;
            if (stallreq_inst_o) hi++;
            else begin
                fin = 1'b1;
                chk("fetch_inst_ack", inst_o, 32'h3C010001);
            end
            next_cycle();
        end
        chk("fetch_done", {31'b0, fin}, 32'd1);
        chk("fetch_stall_cycles", hi, 32'd3);
        chk("fetch_we_sel", bad, 32'd0);
        idle_inputs();
        #4 chk("fetch_inst_hold", inst_o, 32'h3C010001);
        next_cycle();

        // Collision: data load and fetch in the same cycle, 1-cycle ack
        lat = 1; grants.delete();
        inst_ce_i = 1'b1; inst_addr_i = 32'h100;
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200; data_sel_i = 4'hF;
        stall_i = 6'b011110;
        hi = 0; hid = 0; fin = 1'b0;
        for (int c = 0; c < 12 && !fin; c++) begin
            #4;
            if (stallreq_inst_o) hi++;
            if (stallreq_data_o) hid++;
            if (!stallreq_inst_o && !stallreq_data_o) fin = 1'b1;
            next_cycle();
        end
        idle_inputs();
        chk("coll_done", {31'b0, fin}, 32'd1);
        chk("coll_inst_stall_cycles", hi, 32'd3);
        chk("coll_data_stall_cycles", hid, 32'd1);
        chk("coll_grant_count", grants.size(), 32'd2);
        if (grants.size() >= 2) begin
            chk("coll_grant0", grants[0], 32'h200);
            chk("coll_grant1", grants[1], 32'h100);
        end
        #4 chk("coll_data_hold", data_rdata_o, 32'h11112222);
        next_cycle();

        // Store held by an external MEM stall after its ack
        lat = 2; grants.delete();
        data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'b0011;
        data_wdata_i = 32'h0000BEEF; data_addr_i = 32'h204; stall_i = 6'b010000;
        fin = 1'b0;
        for (int c = 0; c < 10 && !fin; c++) begin
            #4;
            if (!stallreq_data_o) fin = 1'b1;
            next_cycle();
        end
        chk("store_done", {31'b0, fin}, 32'd1);
        repeat (4) next_cycle();
        idle_inputs();
        repeat (3) next_cycle();
        chk("store_grant_count", grants.size(), 32'd1);
        if (grants.size() >= 1) chk("store_grant_addr", grants[0], 32'h204);
        chk("store_mem", mem[8'h81], 32'hFFFFBEEF);
        chk("store_rdata_kept", data_rdata_o, 32'h11112222);

        // Flush in the middle of a fetch
        lat = 3; inst_ce_i = 1'b1; inst_addr_i = 32'h108; stall_i = 6'b000010;
        next_cycle();
        flush_i = 1'b1;
        #4;
        chk("flush_ram_ce", {31'b0, ram_ce_o}, 32'd1);
        chk("flush_stallreq", {31'b0, stallreq_inst_o}, 32'd0);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();
        #4;
        chk("flush_inst_kept", inst_o, 32'h3C010001);
        chk("flush_bus_idle", {31'b0, ram_ce_o}, 32'd0);
        next_cycle();

        // Reset while a load is in flight
        lat = 5; data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200;
        data_sel_i = 4'hF; stall_i = 6'b010000;
        next_cycle();
        #4 chk("rstmid_in_flight", {31'b0, ram_ce_o}, 32'd1);
        next_cycle();
        rst = 1'b0; idle_inputs();
        next_cycle();
        rst = 1'b1;
        #4;
        chk("rstmid_ram_ce", {31'b0, ram_ce_o}, 32'd0);
        chk("rstmid_data_rdata", data_rdata_o, 32'd0);
        chk("rstmid_inst_o", inst_o, 32'd0);
        chk("rstmid_stallreqs", {30'b0, stallreq_inst_o, stallreq_data_o}, 32'd0);
        next_cycle();
        lat = 1; data_ce_i = 1'b1; data_addr_i = 32'h204; stall_i = 6'b010000;
        fin = 1'b0;
        for (int c = 0; c < 10 && !fin; c++) begin
            #4;
            if (!stallreq_data_o) begin
                fin = 1'b1;
                chk("rstmid_reload", data_rdata_o, 32'hFFFFBEEF);
            end
            next_cycle();
        end
        chk("rstmid_reload_done", {31'b0, fin}, 32'd1);
        idle_inputs();
        next_cycle();

        // Continuous requests from both ports
        rst = 1'b0;
        next_cycle();
        rst = 1'b1; lat = 1; grants.delete();
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200; data_sel_i = 4'hF;
        inst_ce_i = 1'b1; inst_addr_i = 32'h100; stall_i = '0;
        repeat (9) next_cycle();
        idle_inputs();
        next_cycle();
        chk("cont_grant_count_ge4", {31'b0, grants.size() >= 4}, 32'd1);
        if (grants.size() >= 4) begin
`ifdef ARB_RR_EN
            chk("rr_grant0", grants[0], 32'h200);
            chk("rr_grant1", grants[1], 32'h100);
            chk("rr_grant2", grants[2], 32'h200);
            chk("rr_grant3", grants[3], 32'h100);
`else
            chk("fixed_grant0", grants[0], 32'h200);
            chk("fixed_grant1", grants[1], 32'h200);
            chk("fixed_grant2", grants[2], 32'h200);
            chk("fixed_grant3", grants[3], 32'h200);
`endif
        end

        repeat (2) next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
